sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have ports: m_clock  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: p_reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: wr  in  1  one-cycle CPU register write strobe.
REQ-004 SHALL have: addr  in  2  register offset (0..3 = $4000..$4003 of one pulse channel).
REQ-005 SHALL have: wdata  in  8  write data.
REQ-006 SHALL have: half_frame  in  1  one-cycle half-frame tick from frame counter.
REQ-007 SHALL have: period_in  in  11  current period fed back from sweep unit.
REQ-008 SHALL have outputs e 1, p 3, n 1, s 3: latched sweep parameters.
REQ-009 SHALL have: timer_input  out  11  {timer_hi, timer_lo} reload value.
REQ-010 SHALL have: set_param  out  1  one-cycle parameter-load strobe.
REQ-011 SHALL have: reset  out  1  one-cycle period-reload strobe.
REQ-012 SHALL have: exec  out  1  one-cycle sweep-step strobe.
REQ-013 SHALL have: mute  out  1  combinational channel-mute flag.

Function
REQ-014 wr&addr==1 SHALL latch e=wdata[7], p=wdata[6:4], n=wdata[3], s=wdata[2:0] and set reload_flag.
REQ-015 wr&addr==2 SHALL latch timer_lo=wdata[7:0].
REQ-016 wr&addr==3 SHALL latch timer_hi=wdata[2:0]; wdata[7:3] ignored.
REQ-017 wr&addr==0 SHALL change no state and raise no strobe.
REQ-018 set_param SHALL be high exactly one cycle, the cycle after an addr-1 write, with new e/p/n/s already on outputs.
REQ-019 reset SHALL be high exactly one cycle, the cycle after an addr-3 write, with new timer_input already on outputs.
REQ-020 addr-2 write SHALL update timer_input next cycle without asserting reset.
REQ-021 target SHALL be 12-bit: n=0 -> period_in + (period_in>>s); n=1 -> period_in (no overflow check).
REQ-022 mute SHALL be 1 when period_in<8 or target>0x7FF, else 0.
REQ-023 3-bit divider on half_frame: if divider==0 or reload_flag, divider<=p and reload_flag<=0; else divider<=divider-1.
REQ-024 exec SHALL pulse one cycle after a half_frame where divider==0 (pre-update), e==1, s!=0 and mute==0.
REQ-025 If exec and reset would assert in same cycle, reset SHALL assert and that exec SHALL be dropped (not deferred).
REQ-026 addr-1 write coincident with half_frame: divider step uses old p and old reload_flag; reload_flag SHALL end 1 (write wins).
REQ-027 Back-to-back writes SHALL each produce their own strobe; no strobe stretched beyond one cycle.
REQ-028 half_frame with e==0 SHALL still run the divider per REQ-023.

Reset
REQ-029 p_reset low SHALL immediately clear e,p,n,s,timer_lo,timer_hi,divider,reload_flag and all strobes to 0.
REQ-030 After reset, mute SHALL follow period_in combinationally (period_in=0 -> mute=1).
REQ-031 Reset mid-operation SHALL abort any pending strobe; none emitted after release.

Verification
REQ-032 Write addr1=0x9A -> next cycle set_param=1, e=1, p=1, n=1, s=2; following cycle set_param=0.
REQ-033 Write addr2=0x34, addr3=0xFD -> timer_input=0x534; reset pulses only after addr3 write.
REQ-034 e=1,p=2,s=1,n=0, period_in=0x100, reload_flag set; half_frames 1..7 -> exec after half_frames 2,5 only (one cycle later each).
REQ-035 period_in=0x7F0, s=1, n=0 -> target 0xBE8, mute=1, no exec; n=1 -> mute=0.
REQ-036 period_in=7 -> mute=1 regardless of n,s; period_in=8, s=3, n=0 -> mute=0.
REQ-037 addr3 write timed so reset and exec coincide -> reset=1, exec=0; p_reset low mid-pulse -> all outputs 0 at once.

Source files
------------

// File: rtl/sweep_ctrl.sv
// Sweep register front end for one pulse channel: decodes the $4001..$4003
// CPU writes, holds the sweep parameters and timer reload value, runs the
// half-frame divider, and produces the parameter-load, period-reload and
// sweep-step strobes plus the combinational channel mute.
module sweep_ctrl (
    input  logic        m_clock,
    input  logic        p_reset,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        half_frame,
    input  logic [10:0] period_in,
    output logic        e,
    output logic [2:0]  p,
    output logic        n,
    output logic [2:0]  s,
    output logic [10:0] timer_input,
    output logic        set_param,
    output logic        reset,
    output logic        exec,
    output logic        mute
);

    localparam int unsigned PERIOD_W = 11;
    localparam int unsigned TARGET_W = PERIOD_W + 1;
    localparam int unsigned DIV_W    = 3;
    localparam int unsigned MIN_PERIOD = 8;

    localparam logic [1:0] ADDR_SWEEP    = 2'd1;
    localparam logic [1:0] ADDR_TIMER_LO = 2'd2;
    localparam logic [1:0] ADDR_TIMER_HI = 2'd3;

    logic [7:0]          timer_lo;
    logic [2:0]          timer_hi;
    logic [DIV_W-1:0]    divider;
    logic                reload_flag;

    logic                wr_sweep;
    logic                wr_timer_lo;
    logic                wr_timer_hi;
    logic                div_reload;
    logic                exec_hit;
    logic [TARGET_W-1:0] period_ext;
    logic [TARGET_W-1:0] shift_term;
    logic [TARGET_W-1:0] target;

    // Register write decode; offset 0 belongs to another block and is ignored.
    always_comb begin
        wr_sweep    = 1'b0;
        wr_timer_lo = 1'b0;
        wr_timer_hi = 1'b0;
        if (wr) begin
            wr_sweep    = (addr == ADDR_SWEEP);
            wr_timer_lo = (addr == ADDR_TIMER_LO);
            wr_timer_hi = (addr == ADDR_TIMER_HI);
        end
    end

    // Target period and mute; negate mode leaves the period unchanged here.
    always_comb begin
        period_ext = TARGET_W'(period_in);
        shift_term = '0;
        if (!n) begin
            shift_term = period_ext >> s;
        end
        target = period_ext + shift_term;
        mute   = (period_in < PERIOD_W'(MIN_PERIOD)) || target[TARGET_W-1];
    end

    // Divider step decision and sweep-step qualification, all on pre-update state.
    always_comb begin
        div_reload = (divider == '0) || reload_flag;
        exec_hit   = half_frame && (divider == '0) && e && (s != 3'd0) && !mute;
    end

    // Sweep parameter latch.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            e <= 1'b0;
            p <= '0;
            n <= 1'b0;
            s <= '0;
        end else if (wr_sweep) begin
            e <= wdata[7];
            p <= wdata[6:4];
            n <= wdata[3];
            s <= wdata[2:0];
        end
    end

    // Timer reload value halves.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            timer_lo <= '0;
            timer_hi <= '0;
        end else begin
            if (wr_timer_lo) begin
                timer_lo <= wdata;
            end
            if (wr_timer_hi) begin
                timer_hi <= wdata[2:0];
            end
        end
    end

    assign timer_input = {timer_hi, timer_lo};

    // Half-frame divider; a sweep write in the same cycle re-arms the reload.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            divider     <= '0;
            reload_flag <= 1'b0;
        end else begin
            if (half_frame) begin
                if (div_reload) begin
                    divider <= p;
                end else begin
                    divider <= divider - DIV_W'(1);
                end
            end
            if (wr_sweep) begin
                reload_flag <= 1'b1;
            end else if (half_frame && div_reload) begin
                reload_flag <= 1'b0;
            end
        end
    end

    // One-cycle strobes; a period reload suppresses a coincident sweep step.
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            set_param <= 1'b0;
            reset     <= 1'b0;
            exec      <= 1'b0;
        end else begin
            set_param <= wr_sweep;
            reset     <= wr_timer_hi;
            exec      <= exec_hit && !wr_timer_hi;
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl: a vector table plus hand-written corner sequences.
module tb_sweep_ctrl;

    logic        m_clock = 1'b0;
    logic        p_reset = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  addr = '0;
    logic [7:0]  wdata = '0;
    logic        half_frame = 1'b0;
    logic [10:0] period_in = '0;
    logic        e;
    logic [2:0]  p;
    logic        n;
    logic [2:0]  s;
    logic [10:0] timer_input;
    logic        set_param;
    logic        reset;
    logic        exec;
    logic        mute;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic        hf;
        logic [10:0] per;
        logic        sp;
        logic        rs;
        logic        ex;
        logic        e;
        logic [2:0]  p;
        logic        n;
        logic [2:0]  s;
        logic [10:0] ti;
        logic        mute;
    } vec_t;

    vec_t vecs[$];

    sweep_ctrl dut (
        .m_clock    (m_clock),
        .p_reset    (p_reset),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .half_frame (half_frame),
        .period_in  (period_in),
        .e          (e),
        .p          (p),
        .n          (n),
        .s          (s),
        .timer_input(timer_input),
        .set_param  (set_param),
        .reset      (reset),
        .exec       (exec),
        .mute       (mute)
    );

    always #5 m_clock = ~m_clock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic [1:0] a, input logic [7:0] d,
                       input logic hf, input logic [10:0] per,
                       input logic sp, input logic rs, input logic ex,
                       input logic ee, input logic [2:0] pp, input logic nn,
                       input logic [2:0] ss, input logic [10:0] ti, input logic mu);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.hf = hf; v.per = per;
        v.sp = sp; v.rs = rs; v.ex = ex; v.e = ee; v.p = pp; v.n = nn; v.s = ss;
        v.ti = ti; v.mute = mu;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic w, input logic [1:0] a, input logic [7:0] d,
                         input logic hf, input logic [10:0] per);
        wr = w; addr = a; wdata = d; half_frame = hf; period_in = per;
    endtask

    task automatic step();
        @(posedge m_clock);
        #1;
    endtask

    task automatic do_reset();
        #2 p_reset = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 11'h100);
        step();
        #2 p_reset = 1'b1;
        step();
    endtask

    initial begin
        // wr addr wdata hf period | sp rs ex e p n s ti mute
        add(0,0,8'h00,0,11'h100, 0,0,0, 0,0,0,0, 11'h000, 0);
        add(1,1,8'h9A,0,11'h100, 1,0,0, 1,1,1,2, 11'h000, 0);
        add(0,0,8'h00,0,11'h100, 0,0,0, 1,1,1,2, 11'h000, 0);
        add(1,2,8'h34,0,11'h100, 0,0,0, 1,1,1,2, 11'h034, 0);
        add(1,3,8'hFD,0,11'h100, 0,1,0, 1,1,1,2, 11'h534, 0);
        add(0,0,8'h00,0,11'h100, 0,0,0, 1,1,1,2, 11'h534, 0);
        add(1,0,8'hFF,0,11'h100, 0,0,0, 1,1,1,2, 11'h534, 0);
        add(0,0,8'h00,1,11'h100, 0,0,1, 1,1,1,2, 11'h534, 0);
        add(0,0,8'h00,1,11'h100, 0,0,0, 1,1,1,2, 11'h534, 0);
        add(0,0,8'h00,1,11'h100, 0,0,1, 1,1,1,2, 11'h534, 0);
        add(0,0,8'h00,0,11'h100, 0,0,0, 1,1,1,2, 11'h534, 0);
        add(1,1,8'h9A,0,11'h100, 1,0,0, 1,1,1,2, 11'h534, 0);
        add(1,1,8'h1A,0,11'h100, 1,0,0, 0,1,1,2, 11'h534, 0);
        add(0,0,8'h00,0,11'h100, 0,0,0, 0,1,1,2, 11'h534, 0);
        add(0,0,8'h00,1,11'h100, 0,0,0, 0,1,1,2, 11'h534, 0);
        add(0,0,8'h00,1,11'h100, 0,0,0, 0,1,1,2, 11'h534, 0);
        add(0,0,8'h00,1,11'h100, 0,0,0, 0,1,1,2, 11'h534, 0);
        add(1,1,8'h81,0,11'h100, 1,0,0, 1,0,0,1, 11'h534, 0);
        add(0,0,8'h00,0,11'h7F0, 0,0,0, 1,0,0,1, 11'h534, 1);
        add(0,0,8'h00,1,11'h7F0, 0,0,0, 1,0,0,1, 11'h534, 1);
        add(0,0,8'h00,1,11'h7F0, 0,0,0, 1,0,0,1, 11'h534, 1);
        add(1,1,8'h89,0,11'h7F0, 1,0,0, 1,0,1,1, 11'h534, 0);
        add(0,0,8'h00,1,11'h7F0, 0,0,1, 1,0,1,1, 11'h534, 0);
        add(0,0,8'h00,0,11'h007, 0,0,0, 1,0,1,1, 11'h534, 1);
        add(0,0,8'h00,1,11'h007, 0,0,0, 1,0,1,1, 11'h534, 1);
        add(1,1,8'h83,0,11'h008, 1,0,0, 1,0,0,3, 11'h534, 0);
        add(0,0,8'h00,1,11'h008, 0,0,1, 1,0,0,3, 11'h534, 0);
        add(1,1,8'h80,0,11'h100, 1,0,0, 1,0,0,0, 11'h534, 0);
        add(0,0,8'h00,1,11'h100, 0,0,0, 1,0,0,0, 11'h534, 0);

        // Reset state, including mute following period_in = 0.
        #2;
        check("rst_e", int'(e), 0);
        check("rst_p", int'(p), 0);
        check("rst_n", int'(n), 0);
        check("rst_s", int'(s), 0);
        check("rst_ti", int'(timer_input), 0);
        check("rst_sp", int'(set_param), 0);
        check("rst_rs", int'(reset), 0);
        check("rst_ex", int'(exec), 0);
        check("rst_mute", int'(mute), 1);
        step();
        #2 p_reset = 1'b1;
        step();

        // Table vectors.
        foreach (vecs[i]) begin
            drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hf, vecs[i].per);
            step();
            check($sformatf("v%0d_sp", i), int'(set_param), int'(vecs[i].sp));
            check($sformatf("v%0d_rs", i), int'(reset), int'(vecs[i].rs));
            check($sformatf("v%0d_ex", i), int'(exec), int'(vecs[i].ex));
            check($sformatf("v%0d_e", i), int'(e), int'(vecs[i].e));
            check($sformatf("v%0d_p", i), int'(p), int'(vecs[i].p));
            check($sformatf("v%0d_n", i), int'(n), int'(vecs[i].n));
            check($sformatf("v%0d_s", i), int'(s), int'(vecs[i].s));
            check($sformatf("v%0d_ti", i), int'(timer_input), int'(vecs[i].ti));
            check($sformatf("v%0d_mute", i), int'(mute), int'(vecs[i].mute));
        end

        // Divider sequence from reset; the first half-frame coincides with the write.
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) drive(1'b1, 2'd1, 8'hA1, 1'b1, 11'h100);
            else        drive(1'b0, 2'd0, 8'h00, 1'b1, 11'h100);
            step();
            check($sformatf("div_hf%0d_ex", k), int'(exec), (k == 2 || k == 5) ? 1 : 0);
            drive(1'b0, 2'd0, 8'h00, 1'b0, 11'h100);
            step();
            check($sformatf("div_gap%0d_ex", k), int'(exec), 0);
        end

        // Period reload coincident with a qualifying half-frame: exec is dropped.
        drive(1'b1, 2'd3, 8'h07, 1'b1, 11'h100);
        step();
        check("coin_rs", int'(reset), 1);
        check("coin_ex", int'(exec), 0);
        check("coin_ti", int'(timer_input), 11'h700);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 11'h100);
        step();
        check("coin_rs_end", int'(reset), 0);
        check("coin_ex_late", int'(exec), 0);

        // Asynchronous reset in the middle of a set_param pulse.
        drive(1'b1, 2'd1, 8'hFF, 1'b0, 11'h100);
        step();
        check("mid_sp", int'(set_param), 1);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 11'h100);
        #2 p_reset = 1'b0;
        #1;
        check("mid_sp0", int'(set_param), 0);
        check("mid_e0", int'(e), 0);
        check("mid_p0", int'(p), 0);
        check("mid_s0", int'(s), 0);
        check("mid_ti0", int'(timer_input), 0);
        check("mid_mute_live", int'(mute), 0);
        period_in = 11'h000;
        #1;
        check("mid_mute_zero", int'(mute), 1);
        period_in = 11'h100;
        step();
        #2 p_reset = 1'b1;
        step();
        check("post_sp", int'(set_param), 0);
        check("post_rs", int'(reset), 0);
        check("post_ex", int'(exec), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
